multiplier: RTL
===============

Name: multiplier

Overview:
- Stream-handshake integer multiplier stage for the toolbox arithmetic chain. Sits alongside and downstream of the adder/subtractor stages and interoperates with bend stages.
- Accepts two operand streams (in1, in2) and emits one product stream (out1).
- Uses an iterative shift-add datapath: one partial product per cycle, sized to be cheap in area.
- Output is the low `bits` bits of the product. This is identical for signed two's-complement and unsigned operands.

Parameters:
- bits, 16, width of operands and result

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- in1  input  bits  operand A data
- in1_stb  input  1  operand A valid
- in1_ack  output  1  operand A accepted
- in2  input  bits  operand B data
- in2_stb  input  1  operand B valid
- in2_ack  output  1  operand B accepted
- out1  output  bits  product data
- out1_stb  output  1  product valid
- out1_ack  input  1  product accepted by consumer

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low.
- Transfer rule: a transfer occurs on a rising clk edge where stb and ack are both high. stb or ack alone does nothing.
- All outputs are registered.
- While rst is low, immediately and regardless of clk:
  - in1_ack=0, in2_ack=0, out1_stb=0, out1=0
  - internal accumulator and counter cleared
  - state=GET_A
- States: GET_A -> GET_B -> COMPUTE -> PUT -> GET_A.
- GET_A:
  - in1_ack=1 from the first clk edge after rst releases.
  - On in1 transfer: latch a=in1, drop in1_ack, raise in2_ack, go GET_B.
- GET_B:
  - On in2 transfer: latch b=in2, clear acc and count, drop in2_ack, go COMPUTE.
- COMPUTE, per cycle:
  - If b[0]=1, acc = acc + a (mod 2^bits).
  - Then a = a<<1, b = b>>1, count = count+1.
  - After `bits` iterations: load out1=acc, raise out1_stb, go PUT.
- PUT:
  - out1 and out1_stb held stable until out1_ack is sampled high.
  - On transfer: drop out1_stb, raise in1_ack, go GET_A.
- Latency: out1_stb rises exactly `bits` clk edges after the in2 transfer edge (16 at default).
- Throughput: at most one result per bits+3 cycles.
- Input ordering:
  - in2 presented before in1 is ignored (in2_ack stays 0) until GET_B.
  - in1_stb held during GET_B/COMPUTE/PUT is not accepted.
- Simultaneous in1_stb and in2_stb in GET_A: only in1 transfers that edge. in2 transfers no earlier than the next edge.
- out1_ack high outside PUT: ignored.
- Overflow: silently truncated to low `bits` bits. No flag.
- Reset mid-operation: the partial result is discarded. No out1_stb is emitted for the interrupted operation.

Optional Feature:
- Macro: MULTIPLIER_EARLY_EXIT_EN.
- Defined:
  - In COMPUTE, if the post-shift b equals 0, or count reaches `bits`, go to PUT with the current acc.
  - Latency = max(1, index of highest set bit of the original b + 1) cycles.
  - Examples: b=0 or b=1 -> 1 cycle; b=0x8000 -> 16 cycles.
  - Results are identical to the non-macro build.
- Undefined: latency is fixed at `bits` cycles for all operands.

Test Plan:
- in1=3, in2=5 (no macro) -> out1=0x000F; out1_stb rises exactly 16 edges after the in2 transfer.
- in1=0xFFFD (-3), in2=0x0007 -> out1=0xFFEB (-21).
- in1=0x0100, in2=0x0100 -> out1=0x0000 (truncation, no error).
- Back-pressure: 3*5 with out1_ack held low 10 cycles -> out1 stable at 0x000F, out1_stb high, in1_ack=0 throughout. One cycle after ack, in1_ack=1.
- Reset mid-COMPUTE: pull rst low 8 cycles into 0x1234*0x5678 -> out1_stb=0 and out1=0 without a clock edge, no stale result. After release, 2*2 -> 0x0004.
- With MULTIPLIER_EARLY_EXIT_EN, in1=0x1234:
  - in2=0x0001 -> 0x1234 after 1 cycle.
  - in2=0x0000 -> 0x0000 after 1 cycle.
  - in2=0x8000 -> 0x0000 after 16 cycles.

Source files
------------

// File: rtl/multiplier.sv
// multiplier: stream-handshake iterative shift-add integer multiplier
// Returns the low `bits` bits of in1*in2, which is the same for signed and unsigned operands.
// Ports: clk, rst (async, active-low); in1/in1_stb/in1_ack operand A; in2/in2_stb/in2_ack operand B;
//        out1/out1_stb/out1_ack product. All outputs are registered.
// Optional: define MULTIPLIER_EARLY_EXIT_EN to finish COMPUTE once the remaining multiplier bits are zero.
module multiplier #(
    parameter int bits = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] in1,
    input  logic            in1_stb,
    output logic            in1_ack,
    input  logic [bits-1:0] in2,
    input  logic            in2_stb,
    output logic            in2_ack,
    output logic [bits-1:0] out1,
    output logic            out1_stb,
    input  logic            out1_ack
);
    localparam int CW = $clog2(bits + 1);
    typedef enum logic [1:0] {GET_A, GET_B, COMPUTE, PUT} state_t;
    state_t          state_q, state_d;
    logic [bits-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, out1_q, out1_d;
    logic [bits-1:0] acc_n, b_n;
    logic [CW-1:0]   count_q, count_d;
    logic            in1_ack_q, in1_ack_d, in2_ack_q, in2_ack_d, out1_stb_q, out1_stb_d;
    logic            done;
    always_comb begin
        acc_n      = b_q[0] ? acc_q + a_q : acc_q;
        b_n        = b_q >> 1;
`ifdef MULTIPLIER_EARLY_EXIT_EN
        // no set bits left in b means no further partial products can change acc
        done       = (b_n == '0) || (count_q == CW'(bits - 1));
`else
        done       = count_q == CW'(bits - 1);
`endif
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        count_d    = count_q;
        out1_d     = out1_q;
        out1_stb_d = out1_stb_q;
        in1_ack_d  = in1_ack_q;
        in2_ack_d  = in2_ack_q;
        case (state_q)
            GET_A: begin
                in1_ack_d = 1'b1;
                if (in1_stb && in1_ack_q) begin
                    a_d       = in1;
                    in1_ack_d = 1'b0;
                    in2_ack_d = 1'b1;
                    state_d   = GET_B;
                end
            end
            GET_B: begin
                if (in2_stb && in2_ack_q) begin
                    b_d       = in2;
                    acc_d     = '0;
                    count_d   = '0;
                    in2_ack_d = 1'b0;
                    state_d   = COMPUTE;
                end
            end
            COMPUTE: begin
                acc_d   = acc_n;
                a_d     = a_q << 1;
                b_d     = b_n;
                count_d = count_q + CW'(1);
                if (done) begin
                    out1_d     = acc_n;
                    out1_stb_d = 1'b1;
                    state_d    = PUT;
                end
            end
            PUT: begin
                if (out1_ack && out1_stb_q) begin
                    out1_stb_d = 1'b0;
                    in1_ack_d  = 1'b1;
                    state_d    = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= GET_A;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            out1_q     <= '0;
            out1_stb_q <= 1'b0;
            in1_ack_q  <= 1'b0;
            in2_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            out1_q     <= out1_d;
            out1_stb_q <= out1_stb_d;
            in1_ack_q  <= in1_ack_d;
            in2_ack_q  <= in2_ack_d;
        end
    end
    assign in1_ack  = in1_ack_q;
    assign in2_ack  = in2_ack_q;
    assign out1     = out1_q;
    assign out1_stb = out1_stb_q;
endmodule
